stc_bloader: RTL and testbench
==============================

Name: stc_Bloader

Overview:
- Fetch engine that fills the B-row buffer of the unstructured sparse tensor core.
- On a start pulse it issues K row-read requests to memory over a valid/ready request channel and accepts in-order DW_MEM-wide responses.
- It drives the buffer's write port (write enable, row index, row data), one row per response, then pulses done.
- It sits between the memory interface and the B-row buffer.

Parameters:
- N, 16, columns per B row (N*DW_DATA must equal DW_MEM)
- K, 16, rows per tile, i.e. rows fetched per start
- DW_MEM, 512, memory data width, equal to one B row
- DW_IDX, 4, row-index width (2^DW_IDX >= K)
- DW_DATA, 32, element width
- AW, 32, byte-address width
- ROW_STRIDE, 64, byte distance between consecutive B rows in memory
- MAX_OUT, 4, maximum outstanding read requests (>= 1)

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin a tile fetch; accepted only in IDLE
- base_addr  in  AW  byte address of row 0; sampled on the accepted start
- busy  out  1  high in FETCH and DONE
- done  out  1  one-cycle pulse when the tile is fully written
- rd_req_valid  out  1  read request valid
- rd_req_ready  in  1  memory accepts the request
- rd_req_addr  out  AW  request byte address
- rd_resp_valid  in  1  response data valid; always accepted, no ready signal
- rd_resp_data  in  DW_MEM  response row data
- B_write_en  out  1  buffer write strobe
- B_row  out  DW_IDX  buffer row index
- B_data  out  DW_MEM  buffer row data

Behaviour:
- Reset (async, active-high):
  - State goes to IDLE.
  - Request counter rq, write counter wr and outstanding count oc clear to 0.
  - Every output is 0 while reset is held and after release.
- FSM states IDLE, FETCH, DONE:
  - IDLE -> FETCH when start=1. base_addr is latched; rq, wr and oc are cleared.
  - FETCH -> DONE on the cycle the K-th buffer write is issued (wr reaches K).
  - DONE -> IDLE unconditionally after one cycle. done=1 only in DONE.
  - start is ignored in FETCH and DONE.
- Request channel:
  - rd_req_valid = (state==FETCH) && (rq<K) && (oc<MAX_OUT).
  - rd_req_addr = base_latched + rq*ROW_STRIDE, truncated mod 2^AW.
  - A request fires when rd_req_valid && rd_req_ready; rq increments on fire.
  - Once valid is asserted, valid and addr hold stable until fire. oc cannot rise without a fire, so the MAX_OUT gate never retracts a pending request.
- Outstanding count: oc+1 on fire, oc-1 on response; both in the same cycle leaves oc unchanged.
- Responses:
  - Responses return in request order.
  - A rd_resp_valid seen with oc==0, or outside FETCH, is a protocol violation: it is dropped, causes no write and leaves oc unchanged.
  - For a response at cycle T, the write outputs are registered for cycle T+1: B_write_en=1, B_row=wr[DW_IDX-1:0], B_data=rd_resp_data. wr then increments.
  - B_write_en is 0 in every other cycle. B_row and B_data hold their last values (0 after reset).
- Widths: rq and wr are DW_IDX+1 bits so they can reach K; oc is $clog2(MAX_OUT+1) bits.
- Latency: with a memory of L-cycle response latency and ready tied high, the first write occurs at start+2+L.
- busy: set from the cycle after start is accepted and cleared on return to IDLE.
- Back-to-back tiles: start asserted in the cycle of the DONE->IDLE return is ignored; a start in any later IDLE cycle is accepted.
- Reset mid-operation: everything aborts immediately. Responses arriving after reset are dropped (oc==0) and no write or done is produced.

Decomposition:
- Shared package stc_pkg holds:
  - the state enum (IDLE/FETCH/DONE)
  - localparams for counter widths (DW_IDX+1, $clog2(MAX_OUT+1))
  - the check N*DW_DATA==DW_MEM, enforced by an elaboration-time error
- No sub-module. Counters, FSM and the registered write stage live in one module.

Test Plan (K=16, ROW_STRIDE=64, MAX_OUT=4):
1. Assert reset during random activity -> every output reads 0 immediately and stays 0 after release with no start.
2. start, base_addr=0x1000, ready=1, memory latency 2, data=row# replicated -> requests to 0x1000, 0x1040, …, 0x13C0; exactly 16 writes with B_row 0..15 and matching data; one done pulse; busy drops the cycle after done.
3. Hold rd_req_ready=0 for 5 cycles on the first request -> rd_req_valid=1 and rd_req_addr=0x1000 held stable throughout; one fire only.
4. Memory latency 20 -> rd_req_valid deasserts after 4 fires and reasserts the cycle after the first response; all 16 rows still written in order.
5. base_addr=0xFFFFFFC0 -> second request address is 0x00000000. start pulsed mid-FETCH -> ignored, exactly 16 writes.
6. Reset after 7 writes while 3 requests are outstanding; the memory still returns 3 responses -> no B_write_en, no done. A new start afterwards completes a full 16-row tile.

Source files
------------

// File: rtl/stc_pkg.sv
// Shared types and sizing helpers for the sparse tensor core B-row loader.
package stc_pkg;

  localparam int N          = 16;
  localparam int K          = 16;
  localparam int DW_MEM     = 512;
  localparam int DW_IDX     = 4;
  localparam int DW_DATA    = 32;
  localparam int AW         = 32;
  localparam int ROW_STRIDE = 64;
  localparam int MAX_OUT    = 4;

  localparam int CNT_W = DW_IDX + 1;
  localparam int OC_W  = $clog2(MAX_OUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic int cnt_w(input int dw_idx);
    return dw_idx + 1;
  endfunction

  function automatic int oc_w(input int max_out);
    return $clog2(max_out + 1);
  endfunction

  function automatic bit row_fits(
    input int n,
    input int dw_data,
    input int dw_mem
  );
    return (n * dw_data) == dw_mem;
  endfunction

endpackage

// File: rtl/stc_bloader.sv
// B-row fetch engine: issues K row reads, writes each returned row
// into the B buffer in order, then pulses done.
module stc_bloader
  import stc_pkg::*;
#(
  parameter int N          = stc_pkg::N,
  parameter int K          = stc_pkg::K,
  parameter int DW_MEM     = stc_pkg::DW_MEM,
  parameter int DW_IDX     = stc_pkg::DW_IDX,
  parameter int DW_DATA    = stc_pkg::DW_DATA,
  parameter int AW         = stc_pkg::AW,
  parameter int ROW_STRIDE = stc_pkg::ROW_STRIDE,
  parameter int MAX_OUT    = stc_pkg::MAX_OUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [AW-1:0]     base_addr,
  output logic              busy,
  output logic              done,
  output logic              rd_req_valid,
  input  logic              rd_req_ready,
  output logic [AW-1:0]     rd_req_addr,
  input  logic              rd_resp_valid,
  input  logic [DW_MEM-1:0] rd_resp_data,
  output logic              B_write_en,
  output logic [DW_IDX-1:0] B_row,
  output logic [DW_MEM-1:0] B_data
);

  localparam int CW = cnt_w(DW_IDX);
  localparam int OW = oc_w(MAX_OUT);

  if (!row_fits(N, DW_DATA, DW_MEM)) begin : g_bad_row
    $error("stc_bloader: N*DW_DATA must equal DW_MEM");
  end

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] rq;
  logic [CW-1:0] wr;
  logic [OW-1:0] oc;
  logic [AW-1:0] base;
  logic          go;
  logic          fire;
  logic          resp_ok;

  assign go   = (state == IDLE) && start;
  assign busy = (state != IDLE);
  assign done = (state == DONE);

  assign rd_req_valid = (state == FETCH)
                     && (rq < CW'(K))
                     && (oc < OW'(MAX_OUT));
  assign rd_req_addr  = base + AW'(rq) * AW'(ROW_STRIDE);
  assign fire         = rd_req_valid && rd_req_ready;

  // Stray responses (nothing outstanding, or not fetching) are dropped.
  assign resp_ok = rd_resp_valid
                && (state == FETCH)
                && (oc != '0);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = FETCH;
      FETCH:   if (resp_ok && (wr == CW'(K - 1))) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base <= '0;
      rq   <= '0;
      wr   <= '0;
      oc   <= '0;
    end else if (go) begin
      base <= base_addr;
      rq   <= '0;
      wr   <= '0;
      oc   <= '0;
    end else begin
      if (fire)    rq <= rq + CW'(1);
      if (resp_ok) wr <= wr + CW'(1);
      if (fire && !resp_ok)      oc <= oc + OW'(1);
      else if (!fire && resp_ok) oc <= oc - OW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      B_write_en <= 1'b0;
      B_row      <= '0;
      B_data     <= '0;
    end else begin
      B_write_en <= resp_ok;
      if (resp_ok) begin
        B_row  <= wr[DW_IDX-1:0];
        B_data <= rd_resp_data;
      end
    end
  end

endmodule

// File: tb/tb_stc_bloader.sv
// Scoreboard bench for stc_bloader with a fixed-latency in-order
// memory model.
module tb_stc_bloader;

  localparam int N  = 16;
  localparam int K  = 16;
  localparam int RS = 64;

  typedef struct {
    int           due;
    logic [511:0] data;
  } mem_t;

  typedef struct {
    logic [3:0]   row;
    logic [511:0] data;
  } exp_t;

  logic         clk;
  logic         reset;
  logic         start;
  logic [31:0]  base_addr;
  logic         busy;
  logic         done;
  logic         rd_req_valid;
  logic         rd_req_ready;
  logic [31:0]  rd_req_addr;
  logic         rd_resp_valid;
  logic [511:0] rd_resp_data;
  logic         B_write_en;
  logic [3:0]   B_row;
  logic [511:0] B_data;

  stc_bloader dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .base_addr    (base_addr),
    .busy         (busy),
    .done         (done),
    .rd_req_valid (rd_req_valid),
    .rd_req_ready (rd_req_ready),
    .rd_req_addr  (rd_req_addr),
    .rd_resp_valid(rd_resp_valid),
    .rd_resp_data (rd_resp_data),
    .B_write_en   (B_write_en),
    .B_row        (B_row),
    .B_data       (B_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_t mem_q[$];
  exp_t exp_q[$];

  int checks, errors, cyc, lat, t_start;
  int fires, writes, done_cnt, resp_seen, stall_seen, stall_left;
  int first_wr_cyc, first_resp_cyc, lo_fires, re_cyc, rst_at;
  bit rst_arm, rst_hit, sid_arm, last15;
  bit prev_pend, prev_done, tile_active;
  logic [31:0] cur_base, prev_addr, addr1;

  function automatic bit outs_zero();
    return (busy === 1'b0) && (done === 1'b0)
        && (rd_req_valid === 1'b0) && (rd_req_addr === 32'h0)
        && (B_write_en === 1'b0) && (B_row === 4'h0)
        && (B_data === 512'h0);
  endfunction

  task automatic cycle();
    mem_t m;
    exp_t e;
    logic [31:0] w;
    logic [31:0] ea;
    @(negedge clk);
    if (prev_pend) begin
      checks++;
      if (rd_req_valid !== 1'b1 || rd_req_addr !== prev_addr) begin
        errors++;
        $display("FAIL req_hold valid=%0b addr=%h need valid=1 addr=%h",
                 rd_req_valid, rd_req_addr, prev_addr);
      end
    end
    prev_pend = (rd_req_valid === 1'b1) && !rd_req_ready;
    prev_addr = rd_req_addr;
    if (prev_pend) stall_seen++;
    if (prev_done) begin
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL busy_after_done busy=%b need 0", busy);
      end
    end
    prev_done = (done === 1'b1);
    if (done === 1'b1) done_cnt++;
    if (B_write_en === 1'b1) begin
      checks++;
      writes++;
      if (first_wr_cyc < 0) first_wr_cyc = cyc;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write row=%0d need no write", B_row);
      end else begin
        e = exp_q.pop_front();
        if (B_row !== e.row || B_data !== e.data) begin
          errors++;
          $display("FAIL write row=%0d data=%h need row=%0d data=%h",
                   B_row, B_data[31:0], e.row, e.data[31:0]);
        end
      end
    end
    if (tile_active && fires > 0 && fires < K &&
        rd_req_valid === 1'b0 && lo_fires < 0)
      lo_fires = fires;
    if (lo_fires >= 0 && re_cyc < 0 && rd_req_valid === 1'b1)
      re_cyc = cyc;
    if (rd_req_valid === 1'b1 && rd_req_ready) begin
      ea = cur_base + 32'(fires * RS);
      checks++;
      if (rd_req_addr !== ea) begin
        errors++;
        $display("FAIL req_addr n=%0d addr=%h need %h",
                 fires, rd_req_addr, ea);
      end
      if (fires == 1) addr1 = rd_req_addr;
      w = 32'(fires);
      m.due  = cyc + lat;
      m.data = {N{w}};
      mem_q.push_back(m);
      e.row  = 4'(fires);
      e.data = m.data;
      exp_q.push_back(e);
      fires++;
    end
    if (rd_req_valid === 1'b1 && stall_left > 0) stall_left--;
    @(posedge clk);
    #1;
    cyc++;
    start = 1'b0;
    if (rst_arm && writes == rst_at) begin
      rst_arm = 1'b0;
      rst_hit = 1'b1;
      reset = 1'b1;
      #1;
      checks++;
      if (!outs_zero()) begin
        errors++;
        $display("FAIL reset_abort busy=%b we=%b valid=%b need all 0",
                 busy, B_write_en, rd_req_valid);
      end
      exp_q.delete();
      tile_active = 1'b0;
      prev_pend = 1'b0;
      prev_done = 1'b0;
      resp_seen = 0;
      reset = 1'b0;
    end
    if (sid_arm && last15) begin
      start = 1'b1;
      base_addr = 32'h4000;
      sid_arm = 1'b0;
    end
    rd_req_ready = (stall_left == 0);
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      m = mem_q.pop_front();
      rd_resp_valid = 1'b1;
      rd_resp_data = m.data;
      resp_seen++;
      last15 = (m.data[31:0] == 32'd15);
      if (first_resp_cyc < 0) first_resp_cyc = cyc;
    end else begin
      rd_resp_valid = 1'b0;
      rd_resp_data = '0;
      last15 = 1'b0;
    end
  endtask

  task automatic tile_begin(input logic [31:0] b, input int l,
                            input int stall);
    cur_base = b;
    lat = l;
    stall_left = stall;
    fires = 0;
    writes = 0;
    done_cnt = 0;
    stall_seen = 0;
    first_wr_cyc = -1;
    first_resp_cyc = -1;
    lo_fires = -1;
    re_cyc = -1;
    tile_active = 1'b1;
    prev_done = 1'b0;
    start = 1'b1;
    base_addr = b;
    rd_req_ready = (stall == 0);
    t_start = cyc;
    cycle();
  endtask

  task automatic tile_wait(input bit mid_start);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 600) begin
      if (mid_start && n == 6) begin
        start = 1'b1;
        base_addr = 32'h2000;
      end
      cycle();
      n++;
    end
    checks++;
    if (done_cnt == 0) begin
      errors++;
      $display("FAIL done_timeout cycles=%0d need done", n);
    end
    cycle();
    cycle();
    tile_active = 1'b0;
    checks++;
    if (done_cnt != 1 || writes != K || exp_q.size() != 0) begin
      errors++;
      $display("FAIL tile_count done=%0d writes=%0d left=%0d need 1 16 0",
               done_cnt, writes, exp_q.size());
    end
  endtask

  task automatic test_reset();
    int bad;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (!outs_zero()) begin
      errors++;
      $display("FAIL reset_held busy=%b valid=%b need all 0",
               busy, rd_req_valid);
    end
    reset = 1'b0;
    tile_begin(32'h500, $urandom_range(1, 6), 0);
    repeat ($urandom_range(3, 10)) cycle();
    reset = 1'b1;
    #1;
    checks++;
    if (!outs_zero()) begin
      errors++;
      $display("FAIL reset_async busy=%b valid=%b need all 0",
               busy, rd_req_valid);
    end
    exp_q.delete();
    tile_active = 1'b0;
    prev_pend = 1'b0;
    prev_done = 1'b0;
    repeat (2) cycle();
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (!outs_zero()) bad++;
    end
    checks++;
    if (bad != 0 || mem_q.size() != 0) begin
      errors++;
      $display("FAIL reset_idle nonzero_cycles=%0d need 0", bad);
    end
  endtask

  task automatic test_basic();
    tile_begin(32'h1000, 2, 0);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_set busy=%b need 1", busy);
    end
    tile_wait(1'b0);
    checks++;
    if (first_wr_cyc - t_start != 4) begin
      errors++;
      $display("FAIL first_write_latency got=%0d need 4",
               first_wr_cyc - t_start);
    end
  endtask

  task automatic test_stall();
    tile_begin(32'h1000, 2, 5);
    tile_wait(1'b0);
    checks++;
    if (stall_seen != 5) begin
      errors++;
      $display("FAIL stall_cycles got=%0d need 5", stall_seen);
    end
  endtask

  task automatic test_max_out();
    tile_begin(32'h1000, 20, 0);
    tile_wait(1'b0);
    checks++;
    if (lo_fires != 4) begin
      errors++;
      $display("FAIL max_out fires_at_stall=%0d need 4", lo_fires);
    end
    checks++;
    if (re_cyc != first_resp_cyc + 1) begin
      errors++;
      $display("FAIL reassert cyc=%0d need %0d",
               re_cyc, first_resp_cyc + 1);
    end
  endtask

  task automatic test_wrap_ignore();
    tile_begin(32'hFFFF_FFC0, 2, 0);
    tile_wait(1'b1);
    checks++;
    if (addr1 !== 32'h0) begin
      errors++;
      $display("FAIL addr_wrap addr=%h need 00000000", addr1);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    tile_begin(32'h1000, 3, 0);
    rst_at = 7;
    rst_hit = 1'b0;
    rst_arm = 1'b1;
    n = 0;
    while (!rst_hit && n < 100) begin
      cycle();
      n++;
    end
    checks++;
    if (!rst_hit) begin
      errors++;
      $display("FAIL reset_mid_timeout writes=%0d need 7", writes);
    end
    repeat (10) cycle();
    checks++;
    if (writes != 7 || done_cnt != 0 || resp_seen != 3 ||
        mem_q.size() != 0) begin
      errors++;
      $display("FAIL reset_mid writes=%0d done=%0d resp=%0d need 7 0 3",
               writes, done_cnt, resp_seen);
    end
    tile_begin(32'h6000, 3, 0);
    tile_wait(1'b0);
  endtask

  task automatic test_back_to_back();
    sid_arm = 1'b1;
    tile_begin(32'h3000, 2, 0);
    tile_wait(1'b0);
    repeat (3) cycle();
    checks++;
    if (busy !== 1'b0 || fires != K || sid_arm) begin
      errors++;
      $display("FAIL start_in_done busy=%b fires=%0d need 0 16",
               busy, fires);
    end
    tile_begin(32'h5000, 1, 0);
    tile_wait(1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc = 0;
    lat = 2;
    stall_left = 0;
    rst_arm = 1'b0;
    rst_hit = 1'b0;
    sid_arm = 1'b0;
    last15 = 1'b0;
    prev_pend = 1'b0;
    prev_done = 1'b0;
    tile_active = 1'b0;
    cur_base = '0;
    addr1 = '0;
    reset = 1'b1;
    start = 1'b0;
    base_addr = '0;
    rd_req_ready = 1'b0;
    rd_resp_valid = 1'b0;
    rd_resp_data = '0;
    test_reset();
    test_basic();
    test_stall();
    test_max_out();
    test_wrap_ignore();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
